// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: synchronises pins, detects edges, latches pending bits
// and delivers one unmasked pending pin at a time, round-robin, over valid/ready.
module gpio_irq_ctrl #(
  parameter int NUM_PINS    = 8,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1,
  localparam int ARM_W      = $clog2(SYNC_STAGES + 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] pin_in,
  input  logic [NUM_PINS-1:0] cfg_rise_en,
  input  logic [NUM_PINS-1:0] cfg_fall_en,
  input  logic [NUM_PINS-1:0] irq_mask,
  output logic                irq_valid,
  output logic [ID_W-1:0]     irq_id,
  input  logic                irq_ready,
  output logic [NUM_PINS-1:0] pending,
  output logic [NUM_PINS-1:0] overflow,
  input  logic [NUM_PINS-1:0] ovf_clr
);

  typedef enum logic {IDLE, PRESENT} state_t;

  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [NUM_PINS-1:0] sync_reg [SYNC_STAGES];
  logic [NUM_PINS-1:0] prev_reg;
  logic [ARM_W-1:0]    arm_cnt_reg;
  logic [NUM_PINS-1:0] pending_reg, pending_next;
  logic [NUM_PINS-1:0] overflow_reg, overflow_next;
  logic [ID_W-1:0]     ptr_reg, ptr_next;
  logic [ID_W-1:0]     irq_id_reg, irq_id_next;
  state_t              state_reg, state_next;

  logic                armed;
  logic [NUM_PINS-1:0] level;
  logic [NUM_PINS-1:0] edge_event;
  logic [NUM_PINS-1:0] clr_vec;
  logic [NUM_PINS-1:0] eligible;
  logic                handshake;
  logic                found_hi, found_any;
  logic [ID_W-1:0]     sel_hi, sel_any;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg[gi] <= '0;
        end else if (gi == 0) begin
          sync_reg[gi] <= pin_in;
        end else begin
          sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign level     = sync_reg[SYNC_STAGES-1];
  assign armed     = (arm_cnt_reg == ARM_DONE);
  assign handshake = (state_reg == PRESENT) && irq_ready;
  assign clr_vec   = handshake ? (NUM_PINS'(1) << irq_id_reg) : '0;
  assign eligible  = pending_reg & irq_mask;

  // prev_reg keeps tracking while unarmed so a level held through reset is not an edge
  assign edge_event = armed ? (((level & ~prev_reg) & cfg_rise_en) |
                               ((~level & prev_reg) & cfg_fall_en)) : '0;

  // A handshake clear coinciding with a new edge leaves the pin pending without overflow
  assign pending_next  = (pending_reg & ~clr_vec) | edge_event;
  assign overflow_next = (overflow_reg & ~ovf_clr) |
                         (edge_event & pending_reg & ~clr_vec);

  // Round-robin pick: lowest eligible index at or above the pointer, else lowest overall
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    sel_hi    = '0;
    sel_any   = '0;
    for (int i = NUM_PINS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found_any = 1'b1;
        sel_any   = ID_W'(i);
        if (i >= int'(ptr_reg)) begin
          found_hi = 1'b1;
          sel_hi   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    irq_id_next = irq_id_reg;
    ptr_next    = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (found_any) begin
          irq_id_next = found_hi ? sel_hi : sel_any;
          state_next  = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ready) begin
          ptr_next   = (irq_id_reg == ID_W'(NUM_PINS - 1)) ? '0 : irq_id_reg + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg     <= '0;
      arm_cnt_reg  <= '0;
      pending_reg  <= '0;
      overflow_reg <= '0;
      ptr_reg      <= '0;
      irq_id_reg   <= '0;
      state_reg    <= IDLE;
    end else begin
      prev_reg     <= level;
      if (!armed) begin
        arm_cnt_reg <= arm_cnt_reg + 1'b1;
      end
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      ptr_reg      <= ptr_next;
      irq_id_reg   <= irq_id_next;
      state_reg    <= state_next;
    end
  end

  assign irq_valid = (state_reg == PRESENT);
  assign irq_id    = irq_id_reg;
  assign pending   = pending_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: latency, round-robin order, overflow, masking,
// clear/re-set collision and reset with pins held high.
module tb_gpio_irq_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pin_in;
  logic [N-1:0] cfg_rise_en;
  logic [N-1:0] cfg_fall_en;
  logic [N-1:0] irq_mask;
  logic         irq_valid;
  logic [2:0]   irq_id;
  logic         irq_ready;
  logic [N-1:0] pending;
  logic [N-1:0] overflow;
  logic [N-1:0] ovf_clr;

  int checks = 0;
  int errors = 0;

  gpio_irq_ctrl #(.NUM_PINS(N), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pin_in     (pin_in),
    .cfg_rise_en(cfg_rise_en),
    .cfg_fall_en(cfg_fall_en),
    .irq_mask   (irq_mask),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_ready  (irq_ready),
    .pending    (pending),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_irq(input string tag, input logic v, input logic [2:0] id);
    check({tag, "_valid"}, 32'(irq_valid), 32'(v));
    if (v) check({tag, "_id"}, 32'(irq_id), 32'(id));
  endtask

  initial begin
    rst = 1'b1; pin_in = '0; cfg_rise_en = '0; cfg_fall_en = '0;
    irq_mask = '0; irq_ready = 1'b0; ovf_clr = '0;
    @(negedge clk);
    ticks(2);
    $display("reset: checking idle outputs");
    check("rst_valid", 32'(irq_valid), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Test 1: single rising edge latency
    rst = 1'b0; cfg_rise_en = 8'hFF; irq_mask = 8'hFF; irq_ready = 1'b1;
    ticks(4);
    $display("t1: rise on pin 2");
    pin_in[2] = 1'b1;
    ticks(2);
    check("t1_pend_e1", 32'(pending), 32'h00);
    tick();
    check("t1_pend_e2", 32'(pending), 32'h04);
    check_irq("t1_e2", 1'b0, 3'd0);
    tick();
    check_irq("t1_e3", 1'b1, 3'd2);
    check("t1_pend_e3", 32'(pending), 32'h04);
    tick();
    check_irq("t1_e4", 1'b0, 3'd0);
    check("t1_pend_e4", 32'(pending), 32'h00);

    // Test 2: round-robin from pointer 0, then wrap from pointer 6
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(4);
    $display("t2: pin 2 held through reset, then pins 1,3,5");
    check("t2_no_event", 32'(pending), 32'h00);
    pin_in = 8'h2E;
    ticks(3);
    check("t2_pend", 32'(pending), 32'h2A);
    tick(); check_irq("t2_g1", 1'b1, 3'd1);
    tick(); check_irq("t2_i1", 1'b0, 3'd0);
    check("t2_pend_i1", 32'(pending), 32'h28);
    tick(); check_irq("t2_g3", 1'b1, 3'd3);
    tick(); check_irq("t2_i3", 1'b0, 3'd0);
    tick(); check_irq("t2_g5", 1'b1, 3'd5);
    tick(); check_irq("t2_i5", 1'b0, 3'd0);
    check("t2_pend_i5", 32'(pending), 32'h00);
    $display("t2: pins 0 and 7 together, pointer at 6");
    pin_in = 8'hAF;
    ticks(3);
    check("t2_pend_w", 32'(pending), 32'h81);
    tick(); check_irq("t2_g7", 1'b1, 3'd7);
    tick(); check_irq("t2_i7", 1'b0, 3'd0);
    tick(); check_irq("t2_g0", 1'b1, 3'd0);
    tick(); check_irq("t2_i0", 1'b0, 3'd0);
    pin_in = '0;
    ticks(4);
    check("t2_no_fall", 32'(pending), 32'h00);

    // Test 3: overflow on pin 0 while presented and unacknowledged
    $display("t3: pin 0 pulse with rise+fall, ready low");
    cfg_fall_en = 8'h01; irq_ready = 1'b0;
    pin_in[0] = 1'b1;
    ticks(4);
    check_irq("t3_pres", 1'b1, 3'd0);
    pin_in[0] = 1'b0;
    ticks(2);
    check("t3_ovf_pre", 32'(overflow), 32'h00);
    tick();
    check("t3_ovf", 32'(overflow), 32'h01);
    check("t3_pend", 32'(pending), 32'h01);
    check_irq("t3_hold", 1'b1, 3'd0);
    ovf_clr = 8'h01;
    tick();
    ovf_clr = '0;
    check("t3_ovf_clr", 32'(overflow), 32'h00);
    irq_ready = 1'b1;
    tick();
    check_irq("t3_ack", 1'b0, 3'd0);
    check("t3_pend_ack", 32'(pending), 32'h00);
    cfg_fall_en = '0;

    // Test 4: masked pin stays pending until unmasked
    $display("t4: masked edge on pin 4");
    irq_mask = 8'hEF;
    pin_in[4] = 1'b1;
    ticks(3);
    check("t4_pend", 32'(pending), 32'h10);
    check_irq("t4_masked", 1'b0, 3'd0);
    tick();
    check_irq("t4_masked2", 1'b0, 3'd0);
    irq_mask = 8'hFF;
    tick();
    check_irq("t4_unmask", 1'b1, 3'd4);
    tick();
    check("t4_pend_ack", 32'(pending), 32'h00);

    // Test 5: new edge on the presented pin in the handshake cycle
    $display("t5: pin 6 re-edge during handshake");
    irq_ready = 1'b0;
    pin_in[6] = 1'b1;
    ticks(4);
    check_irq("t5_pres", 1'b1, 3'd6);
    pin_in[6] = 1'b0;
    ticks(3);
    check_irq("t5_hold", 1'b1, 3'd6);
    pin_in[6] = 1'b1;
    ticks(2);
    irq_ready = 1'b1;
    tick();
    check("t5_pend", 32'(pending), 32'h40);
    check("t5_ovf", 32'(overflow), 32'h00);
    check_irq("t5_idle", 1'b0, 3'd0);
    tick();
    check_irq("t5_regrant", 1'b1, 3'd6);
    tick();
    check("t5_pend_ack", 32'(pending), 32'h00);

    // Test 6: async reset mid-PRESENT with all pins high
    $display("t6: all pins high, reset while presenting");
    irq_ready = 1'b0;
    pin_in = 8'hFF;
    ticks(3);
    check("t6_pend", 32'(pending), 32'hAF);
    tick();
    check_irq("t6_pres", 1'b1, 3'd7);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(irq_valid), 32'd0);
    check("t6_rst_id", 32'(irq_id), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'h00);
    check("t6_rst_ovf", 32'(overflow), 32'h00);
    @(negedge clk);
    tick();
    rst = 1'b0;
    irq_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("t6_quiet_valid", 32'(irq_valid), 32'd0);
      check("t6_quiet_pend", 32'(pending), 32'h00);
    end
    check("t6_quiet_ovf", 32'(overflow), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
